wb_write_arbiter: RTL and testbench

- Merges register-file writebacks from the in-order pipeline WB stage and the multi-cycle multiply/divide unit (MDU) onto the single register-file write port.
- Sits directly upstream of the register file and drives its RDaddr/RDdata/RegWrite inputs.
- Buffers MDU results in a small FIFO while the pipeline owns the port.
- Exports a pending-register mask so the hazard unit can stall reads and writes to registers with an outstanding MDU result.

---
 rtl/wb_write_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Merges pipeline WB-stage and MDU writebacks onto the single register-file write port.
// Optional macro WB_MDU_BYPASS_EN enables a same-cycle MDU write when the port and FIFO are idle.
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic signed [31:0] wb_data_i,
  input  logic               mdu_valid_i,
  input  logic [4:0]         mdu_rd_i,
  input  logic signed [31:0] mdu_data_i,
  output logic               mdu_ready_o,
  output logic [4:0]         RDaddr_o,
  output logic signed [31:0] RDdata_o,
  output logic               RegWrite_o,
  output logic [31:0]        pending_mask_o,
  output logic [PTR_W:0]     fifo_count_o
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic signed [31:0] data_q [DEPTH];
  logic [4:0]         rd_q   [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  logic        wb_hit;
  logic        fifo_empty;
  logic        accept;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] pend_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign wb_hit      = wb_valid_i && (wb_rd_i != 5'd0);
  assign fifo_empty  = (count == '0);
  // Ready looks at the count before this cycle's pop, so a full FIFO never accepts.
  assign mdu_ready_o = rst_n && (count < DEPTH_C);
  assign accept      = mdu_valid_i && mdu_ready_o;

`ifdef WB_MDU_BYPASS_EN
  assign bypass = accept && fifo_empty && !wb_hit && (mdu_rd_i != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && (mdu_rd_i != 5'd0) && !bypass;
  assign pop  = rst_n && !wb_hit && !fifo_empty;

  always_comb begin
    RegWrite_o = 1'b0;
    RDaddr_o   = 5'd0;
    RDdata_o   = '0;
    if (rst_n) begin
      if (wb_hit) begin
        RegWrite_o = 1'b1;
        RDaddr_o   = wb_rd_i;
        RDdata_o   = wb_data_i;
      end else if (!fifo_empty) begin
        RegWrite_o = 1'b1;
        RDaddr_o   = rd_q[rd_ptr];
        RDdata_o   = data_q[rd_ptr];
      end else if (bypass) begin
        RegWrite_o = 1'b1;
        RDaddr_o   = mdu_rd_i;
        RDdata_o   = mdu_data_i;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[rd_q[i]] = 1'b1;
    end
  end

  assign pending_mask_o = rst_n ? pend_mask : '0;
  assign fifo_count_o   = rst_n ? count : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= ptr_inc(wr_ptr);
        vld_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= ptr_inc(rd_ptr);
        vld_q[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload is not reset; vld_q qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mdu_data_i;
      rd_q[wr_ptr]   <= mdu_rd_i;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DEPTH = 2;
  localparam int PTR_W = 1;
`ifdef WB_MDU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wb_valid_i = 1'b0;
  logic [4:0]         wb_rd_i = '0;
  logic signed [31:0] wb_data_i = '0;
  logic               mdu_valid_i = 1'b0;
  logic [4:0]         mdu_rd_i = '0;
  logic signed [31:0] mdu_data_i = '0;
  logic               mdu_ready_o;
  logic [4:0]         RDaddr_o;
  logic signed [31:0] RDdata_o;
  logic               RegWrite_o;
  logic [31:0]        pending_mask_o;
  logic [PTR_W:0]     fifo_count_o;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i), .mdu_data_i(mdu_data_i),
    .mdu_ready_o(mdu_ready_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
    .RegWrite_o(RegWrite_o), .pending_mask_o(pending_mask_o), .fifo_count_o(fifo_count_o)
  );

  typedef struct {
    logic        rst_n;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    int          cnt;
    logic [31:0] mask;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  logic last_acc = 1'b0;

  function automatic vec_t mk(logic r, logic wv, logic [4:0] wr, logic [31:0] wd,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic we, logic [4:0] ad, logic [31:0] da,
                              logic rdy, int cnt, logic [31:0] mask);
    vec_t v;
    v.rst_n = r; v.wbv = wv; v.wbrd = wr; v.wbd = wd;
    v.mv = mv; v.mrd = mr; v.md = md;
    v.we = we; v.addr = ad; v.data = da; v.rdy = rdy; v.cnt = cnt; v.mask = mask;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare just after, advance the model at posedge.
  task automatic apply(input vec_t v, input bit use_exp, input string tag);
    logic        m_we, m_rdy, m_pop, m_push, byp, wbw;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_mask, pend;
    int          m_cnt;
    @(negedge clk);
    rst_n = v.rst_n; wb_valid_i = v.wbv; wb_rd_i = v.wbrd; wb_data_i = v.wbd;
    mdu_valid_i = v.mv; mdu_rd_i = v.mrd; mdu_data_i = v.md;
    #1;
    pend = '0;
    foreach (q[i]) pend[q[i].rd] = 1'b1;
    wbw = v.wbv && (v.wbrd != 5'd0);
    assert (!(v.rst_n && wbw && pend[v.wbrd]))
      else $fatal(1, "FAIL hazard: pipeline wrote pending x%0d", v.wbrd);
    m_rdy = v.rst_n && (q.size() < DEPTH);
    m_we = 1'b0; m_addr = '0; m_data = '0; m_pop = 1'b0; byp = 1'b0;
    if (v.rst_n) begin
      if (wbw) begin
        m_we = 1'b1; m_addr = v.wbrd; m_data = v.wbd;
      end else if (q.size() > 0) begin
        m_we = 1'b1; m_addr = q[0].rd; m_data = q[0].data; m_pop = 1'b1;
      end else if (BYP && v.mv && m_rdy && v.mrd != 5'd0) begin
        m_we = 1'b1; m_addr = v.mrd; m_data = v.md; byp = 1'b1;
      end
    end
    m_push = v.mv && m_rdy && (v.mrd != 5'd0) && !byp;
    m_mask = v.rst_n ? pend : '0;
    m_cnt  = v.rst_n ? q.size() : 0;
    if (use_exp) begin
      m_we = v.we; m_addr = v.addr; m_data = v.data; m_rdy = v.rdy;
      m_cnt = v.cnt; m_mask = v.mask;
    end
    chk({tag, ".we"},    32'(RegWrite_o),   32'(m_we));
    chk({tag, ".addr"},  32'(RDaddr_o),     32'(m_addr));
    chk({tag, ".data"},  RDdata_o,          m_data);
    chk({tag, ".ready"}, 32'(mdu_ready_o),  32'(v.rst_n && (use_exp ? v.rdy : m_rdy)));
    chk({tag, ".count"}, 32'(fifo_count_o), 32'(m_cnt));
    chk({tag, ".mask"},  pending_mask_o,    m_mask);
    last_acc = v.mv && v.rst_n && (q.size() < DEPTH);
    @(posedge clk);
    if (!v.rst_n) q.delete();
    else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{rd: v.mrd, data: v.md});
    end
  endtask

  vec_t tbl[11];
  vec_t v;
  logic        r_mv;
  logic [4:0]  r_mrd;
  logic [31:0] r_md;

  initial begin
    //           rst wv wrd wdata      mv mrd mdata      we ad  data       rdy cnt mask
    tbl[0]  = mk(0, 0, 0, 32'h0,     1, 3,  32'h33,    0, 0,  32'h0,     0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 32'h11,    1, 7,  32'h70,    1, 1,  32'h11,    1, 0, 32'h0);
    tbl[2]  = mk(1, 1, 2, 32'h22,    1, 8,  32'h80,    1, 2,  32'h22,    1, 1, 32'h80);
    tbl[3]  = mk(1, 1, 3, 32'h33,    1, 9,  32'h90,    1, 3,  32'h33,    0, 2, 32'h180);
    tbl[4]  = mk(1, 0, 0, 32'h0,     1, 9,  32'h90,    1, 7,  32'h70,    0, 2, 32'h180);
    tbl[5]  = mk(1, 1, 4, 32'h44,    1, 9,  32'h90,    1, 4,  32'h44,    1, 1, 32'h100);
    tbl[6]  = mk(1, 0, 0, 32'h0,     0, 0,  32'h0,     1, 8,  32'h80,    0, 2, 32'h300);
    tbl[7]  = mk(1, 0, 0, 32'h0,     0, 0,  32'h0,     1, 9,  32'h90,    1, 1, 32'h200);
    tbl[8]  = mk(1, 0, 0, 32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 0, 32'h0);
    tbl[9]  = mk(1, 0, 0, 32'h0,     1, 0,  32'h1234,  0, 0,  32'h0,     1, 0, 32'h0);
    tbl[10] = mk(1, 0, 0, 32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 0, 32'h0);
    for (int i = 0; i < 11; i++) apply(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Lone MDU result, latency depends on the bypass build.
    if (BYP) begin
      apply(mk(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF, 1, 0, 32'h0), 1'b1, "lone0");
      apply(mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 32'h0,        1, 0, 32'h0), 1'b1, "lone1");
    end else begin
      apply(mk(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 32'h0),  1'b1, "lone0");
      apply(mk(1, 0, 0, 0, 0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 1, 32'h20), 1'b1, "lone1");
    end
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0), 1'b1, "lone2");

    // Reset while holding two entries.
    apply(mk(1, 1, 1, 32'h101, 1, 10, 32'hA0, 1, 1, 32'h101, 1, 0, 32'h0),   1'b1, "rst0");
    apply(mk(1, 1, 2, 32'h102, 1, 11, 32'hB0, 1, 2, 32'h102, 1, 1, 32'h400), 1'b1, "rst1");
    apply(mk(0, 1, 3, 32'h103, 1, 12, 32'hC0, 0, 0, 32'h0,   0, 0, 32'h0),   1'b1, "rst2");
    apply(mk(1, 0, 0, 32'h0,   0, 0,  32'h0,  0, 0, 32'h0,   1, 0, 32'h0),   1'b1, "rst3");

    // Pipeline valid with rd=0 is not a write, so the FIFO drains.
    apply(mk(1, 1, 1, 32'h1,  1, 12, 32'hC, 1, 1,  32'h1, 1, 0, 32'h0),    1'b1, "x0a");
    apply(mk(1, 1, 0, 32'h55, 0, 0,  32'h0, 1, 12, 32'hC, 1, 1, 32'h1000), 1'b1, "x0b");
    apply(mk(1, 1, 0, 32'h66, 0, 0,  32'h0, 0, 0,  32'h0, 1, 0, 32'h0),    1'b1, "x0c");

    // Random traffic against the model; the MDU holds its offer until accepted.
    r_mv = 1'b0; r_mrd = '0; r_md = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pend;
      logic [4:0]  wr;
      pend = '0;
      foreach (q[i]) pend[q[i].rd] = 1'b1;
      wr = 5'($urandom_range(0, 31));
      for (int k = 0; k < 8 && pend[wr]; k++) wr = 5'($urandom_range(0, 31));
      if (pend[wr]) wr = 5'd0;
      if (!r_mv || last_acc) begin
        r_mv  = ($urandom_range(0, 1) == 1);
        r_mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r_md  = $urandom;
      end
      v = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), wr, $urandom,
             r_mv, r_mrd, r_md, 0, 0, 0, 0, 0, 0);
      apply(v, 1'b0, $sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
